// File: rtl/run_monitor_if.sv
// Processor/dmem/scan signal bundle for the run monitor.
// master = monitor side, slave = processor + memory + result sink.
interface run_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] inst_from_mem;
    logic [DATA_WIDTH-1:0] data_from_mem;
    logic                  proc_reset;
    logic                  mem_sel;
    logic [ADDR_WIDTH-1:0] mon_addr;
    logic                  scan_valid;
    logic [DATA_WIDTH-1:0] scan_word;
    logic [15:0]           scan_index;
    logic [CNT_WIDTH-1:0]  cycle_count;
    logic [1:0]            halt_cause;
    logic [DATA_WIDTH-1:0] checksum;
    logic                  done;

    modport master (
        input  iaddr, inst_from_mem, data_from_mem,
        output proc_reset, mem_sel, mon_addr,
        output scan_valid, scan_word, scan_index,
        output cycle_count, halt_cause, checksum, done
    );

    modport slave (
        output iaddr, inst_from_mem, data_from_mem,
        input  proc_reset, mem_sel, mon_addr,
        input  scan_valid, scan_word, scan_index,
        input  cycle_count, halt_cause, checksum, done
    );
endinterface

// File: rtl/run_monitor.sv
// Run controller: holds the processor in reset, runs it until halt,
// then streams a dmem window out with a running checksum.
module run_monitor #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESET_CYCLES   = 1,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR     = 32'hFFFF_FFFF,
    parameter int                    IMEM_LIMIT     = 4096,
    parameter int                    DUMP_BASE      = 8192,
    parameter int                    DUMP_WORDS     = 46,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic          clock,
    input  logic          reset,
    run_monitor_if.master bus
);
    typedef enum logic [1:0] {
        HOLD,
        RUN,
        SCAN,
        DONE
    } state_t;

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LIMIT     = ADDR_WIDTH'(IMEM_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(DUMP_BASE);
    localparam logic [CNT_WIDTH-1:0]  TMO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]           IDX_LAST  =
        (DUMP_WORDS == 0) ? 16'd0 : 16'(DUMP_WORDS - 1);

    state_t                state;
    state_t                state_nx;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [15:0]           idx;
    logic [1:0]            cause_nx;
    logic                  halt_hit;

    logic [CNT_WIDTH-1:0]  cycle_count;
    logic [1:0]            halt_cause;
    logic                  scan_valid;
    logic [DATA_WIDTH-1:0] scan_word;
    logic [15:0]           scan_index;
    logic [DATA_WIDTH-1:0] checksum;

    // Halt sources in priority order: opcode, fetch range, timeout
    always_comb begin
        cause_nx = 2'b00;
        if (bus.inst_from_mem == HALT_INSTR) begin
            cause_nx = 2'b01;
        end else if (bus.iaddr >= LIMIT) begin
            cause_nx = 2'b10;
        end else if (cycle_count == TMO_LAST) begin
            cause_nx = 2'b11;
        end
        halt_hit = (cause_nx != 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (halt_hit) begin
                    state_nx = (DUMP_WORDS == 0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (idx == IDX_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt    <= '0;
            idx         <= '0;
            cycle_count <= '0;
            halt_cause  <= 2'b00;
            scan_valid  <= 1'b0;
            scan_word   <= '0;
            scan_index  <= '0;
            checksum    <= '0;
        end else begin
            scan_valid <= 1'b0;
            unique case (state)
                HOLD: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + CNT_WIDTH'(1);
                    if (halt_hit) begin
                        halt_cause <= cause_nx;
                    end
                end
                SCAN: begin
                    scan_valid <= 1'b1;
                    scan_word  <= bus.data_from_mem;
                    scan_index <= idx;
                    checksum   <= checksum + bus.data_from_mem;
                    idx        <= idx + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Window address wraps modulo 2^ADDR_WIDTH by construction
    assign bus.mon_addr = (state == SCAN)
        ? BASE + (ADDR_WIDTH'(idx) << 2)
        : '0;

    assign bus.proc_reset  = (state != RUN);
    assign bus.mem_sel     = (state == SCAN);
    assign bus.done        = (state == DONE);
    assign bus.cycle_count = cycle_count;
    assign bus.halt_cause  = halt_cause;
    assign bus.scan_valid  = scan_valid;
    assign bus.scan_word   = scan_word;
    assign bus.scan_index  = scan_index;
    assign bus.checksum    = checksum;
endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: reset hold, halt causes,
// fib window scan with checksum, mid-scan reset abort.
module tb_run_monitor;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic sv_b_seen;

    int checks = 0;
    int errors = 0;

    logic [31:0] fib [0:45];

    always #5 clk = ~clk;

    run_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus_a ();
    run_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus_b ();

    run_monitor #(
        .RESET_CYCLES(3)
    ) dut_a (
        .clock(clk),
        .reset(rst_a),
        .bus  (bus_a)
    );

    run_monitor #(
        .TIMEOUT_CYCLES(20),
        .DUMP_WORDS    (0)
    ) dut_b (
        .clock(clk),
        .reset(rst_b),
        .bus  (bus_b)
    );

    function automatic logic [31:0] dmem(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd8192;
        if (a >= 32'd8192 && a < 32'd8376 && a[1:0] == 2'b00)
            return fib[off[7:2]];
        return 32'hBAD0_0000 ^ a;
    endfunction

    assign bus_a.data_from_mem = dmem(bus_a.mon_addr);
    assign bus_b.data_from_mem = 32'h1234_5678;

    always @(negedge clk)
        if (bus_b.scan_valid === 1'b1) sv_b_seen = 1'b1;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_prst"}, 64'(bus_a.proc_reset), 64'd1);
        check({tag, "_sel"},  64'(bus_a.mem_sel), 64'd0);
        check({tag, "_addr"}, 64'(bus_a.mon_addr), 64'd0);
        check({tag, "_sv"},   64'(bus_a.scan_valid), 64'd0);
        check({tag, "_word"}, 64'(bus_a.scan_word), 64'd0);
        check({tag, "_idx"},  64'(bus_a.scan_index), 64'd0);
        check({tag, "_cnt"},  64'(bus_a.cycle_count), 64'd0);
        check({tag, "_cause"}, 64'(bus_a.halt_cause), 64'd0);
        check({tag, "_sum"},  64'(bus_a.checksum), 64'd0);
        check({tag, "_done"}, 64'(bus_a.done), 64'd0);
    endtask

    task automatic run_a(input int abort_at);
        rst_a = 1'b1;
        bus_a.iaddr = 32'd0;
        bus_a.inst_from_mem = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_a("a_rst");
        rst_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("a_hold_prst", 64'(bus_a.proc_reset), 64'd1);
            check("a_hold_cnt", 64'(bus_a.cycle_count), 64'd0);
            @(negedge clk);
        end
        check("a_run_prst", 64'(bus_a.proc_reset), 64'd0);
        for (int k = 1; k <= 10; k++) begin
            bus_a.iaddr = 32'(4 * (k - 1));
            bus_a.inst_from_mem = (k == 10) ? 32'hFFFF_FFFF : 32'h0000_0013;
            check("a_run_cnt", 64'(bus_a.cycle_count), 64'(k - 1));
            @(negedge clk);
        end
        bus_a.inst_from_mem = 32'h0000_0013;
        check("a_halt_cause", 64'(bus_a.halt_cause), 64'd1);
        check("a_halt_cnt", 64'(bus_a.cycle_count), 64'd10);
        check("a_halt_prst", 64'(bus_a.proc_reset), 64'd1);
        check("a_halt_sel", 64'(bus_a.mem_sel), 64'd1);
        for (int i = 0; i < 46; i++) begin
            check("a_scan_addr", 64'(bus_a.mon_addr), 64'(8192 + 4 * i));
            if (i == abort_at) begin
                rst_a = 1'b1;
                @(negedge clk);
                check_reset_a("a_abort");
                return;
            end
            @(negedge clk);
            check("a_scan_sv", 64'(bus_a.scan_valid), 64'd1);
            check("a_scan_idx", 64'(bus_a.scan_index), 64'(i));
            check("a_scan_word", 64'(bus_a.scan_word), 64'(fib[i]));
            check("a_scan_done", 64'(bus_a.done), 64'(i == 45));
        end
        check("a_sum", 64'(bus_a.checksum), 64'h0000_0000_B119_24E0);
        check("a_cnt_frozen", 64'(bus_a.cycle_count), 64'd10);
        @(negedge clk);
        check("a_done_sv", 64'(bus_a.scan_valid), 64'd0);
        check("a_done_hold", 64'(bus_a.done), 64'd1);
        check("a_done_sel", 64'(bus_a.mem_sel), 64'd0);
        check("a_done_prst", 64'(bus_a.proc_reset), 64'd1);
        check("a_done_sum", 64'(bus_a.checksum), 64'h0000_0000_B119_24E0);
        check("a_done_cause", 64'(bus_a.halt_cause), 64'd1);
    endtask

    task automatic run_b(input string tag, input int halt_k,
                         input logic [31:0] ia, input logic [31:0] ins,
                         input logic [1:0] cause, input int cnt);
        int done_k;
        rst_b = 1'b1;
        bus_b.iaddr = 32'd0;
        bus_b.inst_from_mem = 32'd0;
        repeat (2) @(negedge clk);
        check({tag, "_rst_done"}, 64'(bus_b.done), 64'd0);
        rst_b = 1'b0;
        @(negedge clk);
        check({tag, "_run_prst"}, 64'(bus_b.proc_reset), 64'd0);
        done_k = 0;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            bus_b.iaddr = (k == halt_k) ? ia : 32'(4 * (k - 1));
            bus_b.inst_from_mem = (k == halt_k) ? ins : 32'h0000_0013;
            @(negedge clk);
            if (bus_b.done === 1'b1) done_k = k;
        end
        bus_b.inst_from_mem = 32'h0000_0013;
        check({tag, "_done_k"}, 64'(done_k), 64'(cnt));
        check({tag, "_cause"}, 64'(bus_b.halt_cause), 64'(cause));
        check({tag, "_cnt"}, 64'(bus_b.cycle_count), 64'(cnt));
        check({tag, "_sum"}, 64'(bus_b.checksum), 64'd0);
        check({tag, "_prst"}, 64'(bus_b.proc_reset), 64'd1);
        check({tag, "_sel"}, 64'(bus_b.mem_sel), 64'd0);
    endtask

    initial begin
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int i = 2; i < 46; i++) fib[i] = fib[i-1] + fib[i-2];
        sv_b_seen = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.iaddr = 32'd0;
        bus_a.inst_from_mem = 32'd0;
        bus_b.iaddr = 32'd0;
        bus_b.inst_from_mem = 32'd0;

        run_a(5);
        run_a(-1);

        run_b("b_prio", 3, 32'd4096, 32'hFFFF_FFFF, 2'b01, 3);
        run_b("b_range", 4, 32'd4096, 32'd0, 2'b10, 4);
        run_b("b_tmo", 0, 32'd0, 32'd0, 2'b11, 20);
        check("b_no_scan_valid", 64'(sv_b_seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
